icache_direct_mapped: RTL and testbench

- Direct-mapped, read-only instruction cache directly upstream of the fetch stage. It supplies the fetched instruction word plus a same-cycle hit flag.
- Pipeline stall logic consumes the hit flag: hit low freezes PC and inter-stage registers.
- On a miss it refills one whole line from backing instruction memory over a req/ack word handshake, then resumes hitting.

---
 rtl/icache_direct_mapped.sv | 108 ++++++++++
 tb/tb_icache_direct_mapped.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache with a same-cycle hit flag.
// Misses refill a whole line from backing memory over a word-level req/ack handshake.
module icache_direct_mapped #(
  parameter int INDEX_W  = 4,
  parameter int OFFSET_W = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] pc,
  input  logic        req,
  input  logic        flush,
  output logic [31:0] inst,
  output logic        hit,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data
);

  localparam int TAG_W = 32 - INDEX_W - OFFSET_W - 2;
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << (INDEX_W + OFFSET_W);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_REFILL = 1'b1;

  logic [0:0]          r_state;
  logic [OFFSET_W-1:0] r_cnt;
  logic [TAG_W-1:0]    r_line_tag;
  logic [INDEX_W-1:0]  r_line_index;
  logic [LINES-1:0]    r_valid;
  logic [TAG_W-1:0]    r_tags [LINES];
  logic [31:0]         r_data [WORDS];

  logic [TAG_W-1:0]    w_tag;
  logic [INDEX_W-1:0]  w_index;
  logic [OFFSET_W-1:0] w_word;
  logic                w_idle;
  logic                w_lookup_hit;
  logic                w_miss;
  logic                w_fill;
  logic                w_last;
  logic                w_unused;

  assign w_tag    = pc[31 -: TAG_W];
  assign w_index  = pc[OFFSET_W+2 +: INDEX_W];
  assign w_word   = pc[2 +: OFFSET_W];
  assign w_unused = ^pc[1:0];

  assign w_idle       = (r_state == S_IDLE);
  assign w_lookup_hit = w_idle & req & ~flush & r_valid[w_index] &
                        (r_tags[w_index] == w_tag);
  assign w_miss       = w_idle & req & ~flush & ~w_lookup_hit;
  assign w_fill       = (r_state == S_REFILL) & mem_ack & ~flush;
  assign w_last       = (r_cnt == {OFFSET_W{1'b1}});

  assign hit      = w_lookup_hit;
  assign inst     = w_lookup_hit ? r_data[{w_index, w_word}] : 32'h0;
  assign mem_req  = (r_state == S_REFILL);
  assign mem_addr = {r_line_tag, r_line_index, r_cnt, 2'b00};

  // Flush wins over any refill progress, including an ack arriving in the same cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_line_tag   <= '0;
      r_line_index <= '0;
      r_valid      <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_valid <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_miss) begin
            r_line_tag   <= w_tag;
            r_line_index <= w_index;
            r_cnt        <= '0;
            r_state      <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (mem_ack) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_valid[r_line_index] <= 1'b1;
              r_state               <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Storage arrays carry no reset; the valid bits alone decide whether contents count.
  always_ff @(posedge Clk) begin
    if (w_fill) begin
      r_data[{r_line_index, r_cnt}] <= mem_data;
      if (w_last) begin
        r_tags[r_line_index] <= r_line_tag;
      end
    end
  end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Self-checking bench for icache_direct_mapped: a line-level reference model plus a
// bench-side backing memory image drive directed and randomized fetch scenarios.
module tb_icache_direct_mapped;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        req;
  logic        flush;
  logic [31:0] inst;
  logic        hit;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memAck;
  logic [31:0] memData;

  int checks   = 0;
  int failures = 0;

  bit          modelValid [16];
  logic [23:0] modelTag   [16];

  always #5 clk = ~clk;

  icache_direct_mapped dut (
    .Clk      (clk),
    .Reset    (reset),
    .pc       (pc),
    .req      (req),
    .flush    (flush),
    .inst     (inst),
    .hit      (hit),
    .mem_req  (memReq),
    .mem_addr (memAddr),
    .mem_ack  (memAck),
    .mem_data (memData)
  );

  // Backing memory contents: a fixed program at line 0, a marker pattern at 0x100, hash elsewhere.
  function automatic logic [31:0] memImage(input logic [31:0] addr);
    logic [31:0] value;
    if (addr[31:4] == 28'h0) begin
      case (addr[3:2])
        2'd0:    value = 32'h20080005;
        2'd1:    value = 32'h20090003;
        2'd2:    value = 32'h01095020;
        default: value = 32'h00000000;
      endcase
    end else if (addr[31:4] == 28'h0000010) begin
      value = 32'hAAAA0000 + {30'h0, addr[3:2]};
    end else begin
      value = {addr[15:0] ^ 16'hBEEF, addr[31:16] ^ 16'h1234};
    end
    return value;
  endfunction

  task automatic clearModel();
    foreach (modelValid[i]) modelValid[i] = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyFlush();
    flush = 1'b1;
    req   = 1'b0;
    nextCycle();
    flush = 1'b0;
    clearModel();
  endtask

  // One fetch of address a; on a miss, serves the refill with an ack every 'period' cycles.
  task automatic runFetch(input logic [31:0] a, input int period, input string name);
    logic [3:0]  idx;
    logic [23:0] tagv;
    logic [31:0] base;
    logic [31:0] expData;
    logic [31:0] expAddr;
    bit          expHit;
    int          k;
    int          w;
    idx     = a[7:4];
    tagv    = a[31:8];
    base    = {a[31:4], 4'h0};
    expData = memImage({a[31:2], 2'b00});
    pc      = a;
    req     = 1'b1;
    flush   = 1'b0;
    memAck  = 1'b0;
    memData = 32'h0;
    #1;
    expHit = modelValid[idx] && (modelTag[idx] == tagv);
    checks++;
    if (hit !== expHit) begin
      failures++;
      $display("[TB] FAIL %s lookup_hit: got %b expected %b", name, hit, expHit);
    end
    checks++;
    if (inst !== (expHit ? expData : 32'h0)) begin
      failures++;
      $display("[TB] FAIL %s lookup_inst: got %h expected %h", name, inst,
               expHit ? expData : 32'h0);
    end
    if (!expHit) begin
      checks++;
      if (memReq !== 1'b0) begin
        failures++;
        $display("[TB] FAIL %s miss_cycle_mem_req: got %b expected 0", name, memReq);
      end
      nextCycle();
      k = 0;
      w = 0;
      while (w < 4) begin
        expAddr = base + 32'(4 * w);
        memAck  = ((k % period) == (period - 1));
        memData = memImage(expAddr);
        pc      = $urandom;
        req     = 1'($urandom_range(0, 1));
        #1;
        checks++;
        if (memReq !== 1'b1 || memAddr !== expAddr) begin
          failures++;
          $display("[TB] FAIL %s refill_addr: got req=%b addr=%h expected req=1 addr=%h",
                   name, memReq, memAddr, expAddr);
        end
        checks++;
        if (hit !== 1'b0 || inst !== 32'h0) begin
          failures++;
          $display("[TB] FAIL %s refill_quiet: got hit=%b inst=%h expected hit=0 inst=0",
                   name, hit, inst);
        end
        nextCycle();
        if (memAck) w++;
        k++;
      end
      memAck          = 1'b0;
      pc              = a;
      req             = 1'b1;
      modelValid[idx] = 1'b1;
      modelTag[idx]   = tagv;
      #1;
      checks++;
      if (hit !== 1'b1 || inst !== expData) begin
        failures++;
        $display("[TB] FAIL %s post_refill: got hit=%b inst=%h expected hit=1 inst=%h",
                 name, hit, inst, expData);
      end
    end
    nextCycle();
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    req     = 1'b0;
    flush   = 1'b0;
    pc      = 32'h0;
    memAck  = 1'b0;
    memData = 32'h0;
    clearModel();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (hit !== 1'b0 || inst !== 32'h0 || memReq !== 1'b0 || memAddr !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got hit=%b inst=%h req=%b addr=%h expected all zero",
               hit, inst, memReq, memAddr);
    end
    reset = 1'b0;
    nextCycle();
    for (int i = 0; i < 10; i++) begin
      pc     = $urandom;
      memAck = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (memReq !== 1'b0 || hit !== 1'b0) begin
        failures++;
        $display("[TB] FAIL idle_no_req: got mem_req=%b hit=%b expected 0 0", memReq, hit);
      end
      nextCycle();
    end
    memAck = 1'b0;
  endtask

  task automatic test_cold_miss();
    runFetch(32'h00000000, 1, "cold_w0");
    runFetch(32'h00000004, 1, "cold_w1");
    runFetch(32'h00000008, 1, "cold_w2");
  endtask

  task automatic test_wait_states();
    applyFlush();
    runFetch(32'h00000000, 3, "wait_w0");
    runFetch(32'h0000000C, 1, "wait_w3");
  endtask

  task automatic test_eviction();
    runFetch(32'h00000100, 1, "evict_new");
    runFetch(32'h00000104, 1, "evict_new_w1");
    runFetch(32'h00000000, 1, "evict_old");
  endtask

  task automatic test_flush();
    applyFlush();
    pc  = 32'h00000040;
    req = 1'b1;
    #1;
    checks++;
    if (hit !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_miss: got hit=%b expected 0", hit);
    end
    nextCycle();
    memAck  = 1'b1;
    memData = memImage(32'h40);
    #1;
    checks++;
    if (memAddr !== 32'h40) begin
      failures++;
      $display("[TB] FAIL flush_word0_addr: got %h expected %h", memAddr, 32'h40);
    end
    nextCycle();
    memData = memImage(32'h44);
    flush   = 1'b1;
    #1;
    checks++;
    if (memReq !== 1'b1 || memAddr !== 32'h44 || hit !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_cycle: got req=%b addr=%h hit=%b expected 1 00000044 0",
               memReq, memAddr, hit);
    end
    nextCycle();
    flush = 1'b0;
    req   = 1'b0;
    #1;
    checks++;
    if (memReq !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_drop_req: got %b expected 0", memReq);
    end
    nextCycle();
    memAck = 1'b0;
    clearModel();
    runFetch(32'h00000040, 1, "flush_restart");
    runFetch(32'h00000010, 1, "fill_a");
    runFetch(32'h00000024, 2, "fill_b");
    runFetch(32'h0000003C, 1, "fill_c");
    pc    = 32'h00000010;
    req   = 1'b1;
    flush = 1'b1;
    #1;
    checks++;
    if (hit !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_forces_miss: got hit=%b expected 0", hit);
    end
    nextCycle();
    flush = 1'b0;
    clearModel();
    runFetch(32'h00000010, 1, "after_flush_a");
    runFetch(32'h00000024, 1, "after_flush_b");
    runFetch(32'h0000003C, 1, "after_flush_c");
  endtask

  task automatic test_reset_mid_refill();
    pc  = 32'h00000080;
    req = 1'b1;
    #1;
    nextCycle();
    for (int w = 0; w < 2; w++) begin
      memAck  = 1'b1;
      memData = memImage(32'h80 + 32'(4 * w));
      nextCycle();
    end
    memAck = 1'b0;
    reset  = 1'b1;
    #1;
    checks++;
    if (memReq !== 1'b0 || memAddr !== 32'h0 || hit !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_refill: got req=%b addr=%h hit=%b expected 0 0 0",
               memReq, memAddr, hit);
    end
    memAck = 1'b1;
    nextCycle();
    reset = 1'b0;
    req   = 1'b0;
    #1;
    checks++;
    if (memReq !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ack_after_reset: got mem_req=%b expected 0", memReq);
    end
    nextCycle();
    memAck = 1'b0;
    clearModel();
    runFetch(32'h00000080, 2, "reset_restart");
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      a = {22'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      runFetch(a, $urandom_range(1, 3), "random");
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_cold_miss();
    test_wait_states();
    test_eviction();
    test_flush();
    test_reset_mid_refill();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
